// File: rtl/perceptron_introduction_core_if.sv
// Activation encoding plus the perceptron's operand/result bundle.
// The master drives operands and training controls; the slave returns prediction and done_training.
package perceptron_introduction_pkg;
    typedef enum logic [1:0] {
        ACT_HEAVISIDE = 2'd0,
        ACT_SIGN      = 2'd1,
        ACT_RELU      = 2'd2,
        ACT_IDENTITY  = 2'd3
    } act_func;
endpackage

interface perceptron_introduction_core_if #(
    parameter int input_units     = 2,
    parameter int training_inputs = 4
);
    import perceptron_introduction_pkg::*;

    logic signed [31:0] values        [input_units];
    act_func            activation;
    logic               training;
    logic signed [31:0] epochs;
    logic signed [31:0] learning_rate;
    logic signed [31:0] train_values  [training_inputs][input_units];
    logic signed [31:0] expected      [training_inputs];
    logic signed [31:0] prediction;
    logic               done_training;

    modport master (
        output values, activation, training, epochs, learning_rate, train_values, expected,
        input  prediction, done_training
    );

    modport slave (
        input  values, activation, training, epochs, learning_rate, train_values, expected,
        output prediction, done_training
    );
endinterface

// File: rtl/perceptron_introduction_core.sv
// Single perceptron: registered inference every cycle plus an on-line training FSM.
// Latency: prediction is 1 cycle after values; one training sample is consumed per cycle.
// Backpressure: none; training is a level request and inputs must be held stable while training.
module perceptron_introduction_core
    import perceptron_introduction_pkg::*;
#(
    parameter int input_units     = 2,
    parameter int training_inputs = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    perceptron_introduction_core_if.slave bus
);
    localparam int kw = (training_inputs > 1) ? $clog2(training_inputs) : 1;
    localparam logic [kw-1:0] k_last = kw'(training_inputs - 1);

    typedef enum logic [1:0] {IDLE, TRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic signed [31:0] w [input_units];
    logic signed [31:0] b;
    logic [kw-1:0]      k;
    logic signed [31:0] ep;
    logic signed [31:0] ep_cap;
    logic signed [31:0] prediction_q;

    logic               upd, cap, clr, last_sample;
    logic signed [31:0] inf_sum, trn_sum, trn_act, err, step;

    function automatic logic signed [31:0] act_fn(act_func a, logic signed [31:0] s);
        case (a)
            ACT_HEAVISIDE: return (s > 0) ? 32'sd1 : 32'sd0;
            ACT_SIGN:      return (s > 0) ? 32'sd1 : ((s < 0) ? -32'sd1 : 32'sd0);
            ACT_RELU:      return (s > 0) ? s : 32'sd0;
            default:       return s;
        endcase
    endfunction

    // Both sums use the pre-update weights; products wrap to 32 bits.
    always_comb begin
        inf_sum = b;
        trn_sum = b;
        for (int i = 0; i < input_units; i++) begin
            inf_sum = inf_sum + w[i] * bus.values[i];
            trn_sum = trn_sum + w[i] * bus.train_values[k][i];
        end
        trn_act = act_fn(bus.activation, trn_sum);
        err     = bus.expected[k] - trn_act;
        step    = bus.learning_rate * err;
    end

    assign last_sample = (k == k_last) && (ep == ep_cap - 32'sd1);

    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        cap       = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.training) begin
                    cap       = 1'b1;
                    state_nxt = (bus.epochs <= 0) ? DONE : TRAIN;
                end
            end
            TRAIN: begin
                if (!bus.training) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    upd = 1'b1;
                    if (last_sample) state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bus.training) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            b            <= '0;
            k            <= '0;
            ep           <= '0;
            ep_cap       <= '0;
            prediction_q <= '0;
            for (int i = 0; i < input_units; i++) w[i] <= '0;
        end else begin
            state        <= state_nxt;
            prediction_q <= act_fn(bus.activation, inf_sum);
            if (cap) begin
                k      <= '0;
                ep     <= '0;
                ep_cap <= bus.epochs;
            end else if (clr) begin
                k  <= '0;
                ep <= '0;
            end else if (upd) begin
                for (int i = 0; i < input_units; i++)
                    w[i] <= w[i] + step * bus.train_values[k][i];
                b <= b + step;
                if (k == k_last) begin
                    k  <= '0;
                    ep <= ep + 32'sd1;
                end else begin
                    k <= k + kw'(1);
                end
            end
        end
    end

    assign bus.prediction    = prediction_q;
    assign bus.done_training = (state == DONE);
endmodule

// File: tb/tb_perceptron_introduction_core.sv
// Bench for perceptron_introduction_core: AND training, inference tables, abort/resume and reset cases.
module tb_perceptron_introduction_core;
    import perceptron_introduction_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perceptron_introduction_core_if #(.input_units(2), .training_inputs(4)) bus();

    perceptron_introduction_core #(.input_units(2), .training_inputs(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        act_func            act;
        logic signed [31:0] v0;
        logic signed [31:0] v1;
        logic signed [31:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    int and_x0[4] = '{1, 0, 1, 0};
    int and_x1[4] = '{1, 1, 0, 0};
    int and_t [4] = '{1, 0, 0, 0};
    int mw0, mw1, mb;

    vec_t tbl_zero[4];
    vec_t tbl_and[12];

    task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic apply_pred(input act_func a, input int v0, input int v1, input int e, input string name);
        bus.activation = a;
        bus.values[0]  = v0;
        bus.values[1]  = v1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        check(name, bus.prediction, exp_q.pop_front());
    endtask

    task automatic check_weights(input int ew0, input int ew1, input int eb, input string tag);
        apply_pred(ACT_IDENTITY, 0, 0, eb,       {tag, "_b"});
        apply_pred(ACT_IDENTITY, 1, 0, ew0 + eb, {tag, "_w0"});
        apply_pred(ACT_IDENTITY, 0, 1, ew1 + eb, {tag, "_w1"});
        bus.activation = ACT_HEAVISIDE;
    endtask

    // Caller has raised training while IDLE; counts cycles from TRAIN entry to done.
    task automatic run_to_done(input int exp_cycles, input string name);
        int n;
        n = 0;
        @(posedge clk); #1;
        check({name, "_entry_not_done"}, 32'(bus.done_training), 0);
        while (!bus.done_training && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    // Reference perceptron update for the AND set with Heaviside and learning rate 1.
    task automatic model_train(input int n_samples);
        int s, y, e;
        for (int j = 0; j < n_samples; j++) begin
            s = mb + mw0 * and_x0[j % 4] + mw1 * and_x1[j % 4];
            y = (s > 0) ? 1 : 0;
            e = and_t[j % 4] - y;
            mw0 += e * and_x0[j % 4];
            mw1 += e * and_x1[j % 4];
            mb  += e;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        tbl_zero[0] = '{ACT_IDENTITY,  5, -3, 0};
        tbl_zero[1] = '{ACT_SIGN,      7,  7, 0};
        tbl_zero[2] = '{ACT_HEAVISIDE, 1,  1, 0};
        tbl_zero[3] = '{ACT_RELU,      9,  2, 0};

        // Expected with trained weights w0=2, w1=1, b=-2.
        tbl_and[0]  = '{ACT_HEAVISIDE, 0, 0, 0};
        tbl_and[1]  = '{ACT_HEAVISIDE, 1, 0, 0};
        tbl_and[2]  = '{ACT_HEAVISIDE, 0, 1, 0};
        tbl_and[3]  = '{ACT_HEAVISIDE, 1, 1, 1};
        tbl_and[4]  = '{ACT_IDENTITY,  0, 0, -2};
        tbl_and[5]  = '{ACT_IDENTITY,  1, 0, 0};
        tbl_and[6]  = '{ACT_IDENTITY,  0, 1, -1};
        tbl_and[7]  = '{ACT_SIGN,      0, 1, -1};
        tbl_and[8]  = '{ACT_SIGN,      1, 1, 1};
        tbl_and[9]  = '{ACT_RELU,      3, 0, 4};
        tbl_and[10] = '{ACT_RELU,      0, 1, 0};
        tbl_and[11] = '{ACT_IDENTITY,  32'h7fffffff, 0, -4};

        bus.training      = 1'b0;
        bus.epochs        = 5;
        bus.learning_rate = 1;
        bus.activation    = ACT_HEAVISIDE;
        bus.values[0]     = 0;
        bus.values[1]     = 0;
        for (int k = 0; k < 4; k++) begin
            bus.train_values[k][0] = and_x0[k];
            bus.train_values[k][1] = and_x1[k];
            bus.expected[k]        = and_t[k];
        end

        #12;
        check("reset_prediction", bus.prediction, 0);
        check("reset_done", 32'(bus.done_training), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++)
            apply_pred(tbl_zero[i].act, tbl_zero[i].v0, tbl_zero[i].v1, tbl_zero[i].exp, $sformatf("untrained_%0d", i));

        // Zero epochs: straight to DONE, no updates.
        bus.activation = ACT_HEAVISIDE;
        bus.epochs     = 0;
        bus.training   = 1'b1;
        @(posedge clk); #1;
        check("zero_epoch_done", 32'(bus.done_training), 1);
        apply_pred(ACT_HEAVISIDE, 1, 1, 0, "zero_epoch_pred11");
        check_weights(0, 0, 0, "zero_epoch");
        bus.training = 1'b0;
        @(posedge clk); #1;
        check("zero_epoch_release", 32'(bus.done_training), 0);

        // Full AND run.
        bus.epochs   = 5;
        bus.training = 1'b1;
        run_to_done(20, "and_latency");
        for (int i = 0; i < 12; i++)
            apply_pred(tbl_and[i].act, tbl_and[i].v0, tbl_and[i].v1, tbl_and[i].exp, $sformatf("and_tbl_%0d", i));
        check("and_done_held", 32'(bus.done_training), 1);
        bus.activation = ACT_HEAVISIDE;
        bus.training   = 1'b0;
        @(posedge clk); #1;
        check("and_done_release", 32'(bus.done_training), 0);

        // Reset mid-training.
        do_reset();
        bus.values[0] = 1;
        bus.values[1] = 1;
        bus.training  = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_reset_pred", bus.prediction, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_pred", bus.prediction, 0);
        check("midreset_done", 32'(bus.done_training), 0);
        bus.training = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_weights(0, 0, 0, "after_reset");
        bus.training = 1'b1;
        run_to_done(20, "rerun_latency");
        check_weights(2, 1, -2, "rerun");
        bus.training = 1'b0;
        @(posedge clk); #1;

        // Abort after 6 samples, then resume from current weights.
        do_reset();
        mw0 = 0; mw1 = 0; mb = 0;
        bus.training = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        bus.training = 1'b0;
        @(posedge clk); #1;
        check("abort_done", 32'(bus.done_training), 0);
        model_train(6);
        check_weights(mw0, mw1, mb, "abort");
        repeat (4) begin @(posedge clk); #1; end
        check_weights(mw0, mw1, mb, "abort_frozen");
        bus.training = 1'b1;
        run_to_done(20, "resume_latency");
        model_train(20);
        check_weights(mw0, mw1, mb, "resume");
        bus.training = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
